mac_buffer_ctrl: RTL

MAC_BUFFER_CTRL -- requirements
Module: mac_buffer_ctrl

---
 rtl/mac_buffer_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mac_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// mac_buffer_ctrl
//
// Pointer and occupancy controller for the circular operand buffer that sits
// between an operand producer and the MAC consumer. The data array itself
// lives outside this block; this block decides which requests are granted,
// which slot each accepted write or read targets, and how full the buffer is.
//
// A drain command (Flush) stops the producer side and lets the consumer empty
// the buffer. When the last operand has been read, Done pulses for one cycle.
//
// Full and empty are told apart with a wrap-parity bit per pointer. Each
// pointer toggles its bit every time it wraps from the last slot back to 0.
// Equal addresses with equal parity mean empty. Equal addresses with
// different parity mean full.
//
// Ports
//   Clk      single clock, rising edge
//   Rst      asynchronous, active-high reset
//   W_Req    producer asks to write one operand
//   R_Req    consumer asks to read one operand
//   Flush    drain command (honoured only while actively filling)
//   W_Grant  write accepted this cycle (combinational)
//   R_Grant  read accepted this cycle (combinational)
//   W_Addr   slot targeted by the next accepted write
//   R_Addr   slot targeted by the next accepted read
//   Round    write wrap parity XOR read wrap parity
//   Full     every slot holds unread data
//   Empty    no slot holds unread data
//   Count    number of occupied slots, 0..BufferSize
//   Ready    bit i set when slot i holds unread data
//   Done     one-cycle pulse after a drain has completed
// ---------------------------------------------------------------------------
module mac_buffer_ctrl #(
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   W_Req,
    input  logic                   R_Req,
    input  logic                   Flush,
    output logic                   W_Grant,
    output logic                   R_Grant,
    output logic [BufferWidth-1:0] W_Addr,
    output logic [BufferWidth-1:0] R_Addr,
    output logic                   Round,
    output logic                   Full,
    output logic                   Empty,
    output logic [BufferWidth:0]   Count,
    output logic [BufferSize-1:0]  Ready,
    output logic                   Done
);

    // The buffer holds a power-of-two number of slots. Pointer arithmetic
    // therefore wraps naturally at the top slot, and the count needs one
    // extra bit so that it can represent a completely full buffer.
    localparam logic [BufferWidth-1:0] LastSlot  = BufferWidth'(BufferSize - 1);
    localparam logic [BufferWidth:0]   SlotCount = (BufferWidth + 1)'(BufferSize);
    localparam logic [BufferWidth:0]   OneEntry  = (BufferWidth + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    state_e                 state_q,   state_d;
    logic [BufferWidth-1:0] w_addr_q,  w_addr_d;
    logic [BufferWidth-1:0] r_addr_q,  r_addr_d;
    logic                   w_round_q, w_round_d;
    logic                   r_round_q, r_round_d;
    logic                   done_q,    done_d;

    logic                   round;
    logic                   ptr_equal;
    logic                   full;
    logic                   empty;
    logic [BufferWidth:0]   count;
    logic [BufferWidth-1:0] wr_diff;
    logic [BufferWidth-1:0] rw_diff;
    logic [BufferWidth-1:0] ready_offset;
    logic [BufferSize-1:0]  ready;
    logic                   w_grant;
    logic                   r_grant;
    logic                   flush_exit;

    // All control state sits behind the asynchronous reset. Reset discards
    // every outstanding operand and any pending Done pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            w_round_q <= 1'b0;
            r_round_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_addr_q  <= w_addr_d;
            r_addr_q  <= r_addr_d;
            w_round_q <= w_round_d;
            r_round_q <= r_round_d;
            done_q    <= done_d;
        end
    end

    // Occupancy status is derived from the two pointers and their wrap
    // parity. When the parities differ, the writer has lapped the reader once.
    // The distance is then measured the other way round and taken from the
    // slot count. This makes a full buffer report BufferSize rather than 0.
    always_comb begin
        round     = w_round_q ^ r_round_q;
        ptr_equal = (w_addr_q == r_addr_q);
        full      = ptr_equal & round;
        empty     = ptr_equal & ~round;
        wr_diff   = w_addr_q - r_addr_q;
        rw_diff   = r_addr_q - w_addr_q;
        if (round) begin
            count = SlotCount - {1'b0, rw_diff};
        end else begin
            count = {1'b0, wr_diff};
        end
    end

    // A slot is occupied when its distance ahead of the read pointer is
    // smaller than the occupancy. This handles the wrapped interval
    // [R_Addr, W_Addr) without special cases. It also gives all-ones when
    // full and all-zeros when empty.
    always_comb begin
        ready        = '0;
        ready_offset = '0;
        for (int i = 0; i < BufferSize; i++) begin
            ready_offset = BufferWidth'(i) - r_addr_q;
            ready[i]     = ({1'b0, ready_offset} < count);
        end
    end

    // Writes are refused while draining or when no slot is free. Reads are
    // refused only when nothing is stored. Because of these two rules, a full
    // buffer with both requests grants only the read, and an empty buffer
    // with both requests grants only the write. Both grants are held low
    // while reset is asserted, so nothing is acknowledged that reset is
    // about to discard.
    always_comb begin
        w_grant = W_Req & ~full & (state_q != ST_FLUSH) & ~Rst;
        r_grant = R_Req & ~empty & ~Rst;
    end

    // The drain ends in one of two ways. The buffer may already be empty.
    // Otherwise, the single remaining operand is read this cycle; no write
    // can refill the buffer during a drain, so this read empties it.
    always_comb begin
        flush_exit = (state_q == ST_FLUSH) &&
                     (empty || (r_grant && (count == OneEntry)));
    end

    // Control sequencing:
    //   IDLE   leaves on the first producer request.
    //   ACTIVE enters the drain when Flush arrives. A write requested in that
    //          same cycle is still granted.
    //   FLUSH  returns to IDLE once the buffer is empty.
    // Flush is ignored in IDLE and in FLUSH. Done is registered, so it
    // appears in the first IDLE cycle after the drain.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (W_Req) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (Flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_exit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Each pointer advances by one slot per granted access. When a pointer
    // steps past the last slot, it returns to 0 and flips its wrap parity.
    // The two pointers move independently, so a simultaneous read and write
    // leaves the occupancy unchanged.
    always_comb begin
        w_addr_d  = w_addr_q;
        w_round_d = w_round_q;
        r_addr_d  = r_addr_q;
        r_round_d = r_round_q;
        if (w_grant) begin
            if (w_addr_q == LastSlot) begin
                w_addr_d  = '0;
                w_round_d = ~w_round_q;
            end else begin
                w_addr_d = w_addr_q + BufferWidth'(1);
            end
        end
        if (r_grant) begin
            if (r_addr_q == LastSlot) begin
                r_addr_d  = '0;
                r_round_d = ~r_round_q;
            end else begin
                r_addr_d = r_addr_q + BufferWidth'(1);
            end
        end
    end

    assign W_Grant = w_grant;
    assign R_Grant = r_grant;
    assign W_Addr  = w_addr_q;
    assign R_Addr  = r_addr_q;
    assign Round   = round;
    assign Full    = full;
    assign Empty   = empty;
    assign Count   = count;
    assign Ready   = ready;
    assign Done    = done_q;

endmodule
